deser_sched: RTL

- Sequences a serial-to-parallel block. Accepts N_SAMPLES serial samples over a val/rdy handshake.
- For each accepted sample, drives a one-hot-capable slot select and write enable into the external register-bank datapath.
- Once all slots are filled, presents the parallel word downstream with its own val/rdy handshake.
- Sits between the upstream sample source and the parallel datapath (demux plus register bank). Contains no data storage itself.

---
 rtl/deser_pkg.sv | 21 ++
 rtl/deser_idx_ctr.sv | 50 +++++
 rtl/deser_sched.sv | 131 +++++++++++++
 3 files changed

// File: rtl/deser_pkg.sv
// Shared definitions for the serial-to-parallel scheduler.
//
// Contents:
//   state_e   - scheduler state: FILL collects samples, DRAIN presents the word
//   sel_w()   - width of the slot select / index for a given slot count
//
// Optional feature macro used by the files importing this package:
//   DESER_SCHED_PARTIAL_FLUSH_EN
package deser_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // Slot count is at least 2, so $clog2 always yields a width of at least 1.
  function automatic int sel_w(input int n_samples);
    return $clog2(n_samples);
  endfunction

endpackage

// File: rtl/deser_idx_ctr.sv
// Modulo-N_SAMPLES slot index counter.
//
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-high reset (index to 0)
//   inc    in   advance the index by one, wrapping after N_SAMPLES-1
//   clr    in   return the index to 0 (wins over inc)
//   idx    out  current slot index (registered)
//   wrap   out  inc while idx is at the last slot (combinational)
module deser_idx_ctr #(
  parameter int N_SAMPLES = 8,
  parameter int SEL_W     = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [SEL_W-1:0] idx,
  output logic             wrap
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_SAMPLES - 1);

  logic [SEL_W-1:0] idx_q;
  logic [SEL_W-1:0] idx_d;
  logic             at_last;

  always_comb begin
    at_last = (idx_q == LAST);
    wrap    = inc && at_last;
    idx_d   = idx_q;
    if (clr) begin
      idx_d = '0;
    end else if (inc) begin
      // Explicit compare so non-power-of-two counts wrap at N_SAMPLES-1.
      idx_d = at_last ? '0 : idx_q + SEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx = idx_q;

endmodule

// File: rtl/deser_sched.sv
// Serial-to-parallel frame scheduler. Accepts N_SAMPLES serial samples,
// steering each into the external register bank via wr_en/wr_sel, then
// presents the completed parallel word downstream. Holds no data itself.
//
// Handshakes: a transfer happens on a rising CLK edge where valid and ready
// are both 1. A valid, once raised, stays high and stable until accepted;
// ready may be withheld for any number of cycles.
//
// Ports:
//   CLK         in   clock
//   RESET       in   synchronous active-high reset; discards any partial frame
//   recv_val    in   upstream sample valid
//   recv_rdy    out  sample can be accepted (high throughout FILL)
//   send_val    out  parallel word valid (high throughout DRAIN)
//   send_rdy    in   downstream accepts the parallel word
//   wr_en       out  register-bank write strobe (recv_val & recv_rdy)
//   wr_sel      out  slot written while wr_en=1
//   frame_busy  out  a slot of the current frame is filled, or draining
//   state_dbg   out  current scheduler state
//   flush       in   (DESER_SCHED_PARTIAL_FLUSH_EN) close a partial frame
//   send_len    out  (DESER_SCHED_PARTIAL_FLUSH_EN) valid slots in the word
//
// Optional feature macro: DESER_SCHED_PARTIAL_FLUSH_EN.
module deser_sched
  import deser_pkg::*;
#(
  parameter int N_SAMPLES = 8,
  parameter int SEL_W     = sel_w(N_SAMPLES)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             recv_val,
  output logic             recv_rdy,
  output logic             send_val,
  input  logic             send_rdy,
  output logic             wr_en,
  output logic [SEL_W-1:0] wr_sel,
  output logic             frame_busy,
  output state_e           state_dbg
`ifdef DESER_SCHED_PARTIAL_FLUSH_EN
  ,
  input  logic             flush,
  output logic [SEL_W:0]   send_len
`endif
);

  state_e           state_q;
  state_e           state_d;
  logic [SEL_W-1:0] idx;
  logic             idx_wrap;
  logic             idx_clr;
  logic             xfer;
  logic             send_fire;
  logic             flush_go;

  deser_idx_ctr #(
    .N_SAMPLES (N_SAMPLES),
    .SEL_W     (SEL_W)
  ) u_idx_ctr (
    .clk   (CLK),
    .reset (RESET),
    .inc   (xfer),
    .clr   (idx_clr),
    .idx   (idx),
    .wrap  (idx_wrap)
  );

`ifdef DESER_SCHED_PARTIAL_FLUSH_EN
  localparam logic [SEL_W:0] N_LEN = (SEL_W + 1)'(N_SAMPLES);

  logic [SEL_W:0] send_len_q;
  logic [SEL_W:0] send_len_d;
`endif

  always_comb begin
    // Handshake outputs depend only on registered state; RESET merely masks.
    recv_rdy   = !RESET && (state_q == FILL);
    send_val   = !RESET && (state_q == DRAIN);
    xfer       = recv_val && recv_rdy;
    wr_en      = xfer;
    wr_sel     = RESET ? '0 : idx;
    frame_busy = !RESET && ((state_q == DRAIN) || (idx != '0));
    send_fire  = send_val && send_rdy;
    state_dbg  = state_q;

    flush_go = 1'b0;
`ifdef DESER_SCHED_PARTIAL_FLUSH_EN
    // A flush on an empty frame with no sample arriving has nothing to send.
    flush_go = flush && recv_rdy && (xfer || (idx != '0));
`endif

    // Flush restarts the index; the sample written this cycle is still counted
    // through send_len below.
    idx_clr = send_fire || flush_go;

    state_d = state_q;
    case (state_q)
      FILL:    if (idx_wrap || flush_go) state_d = DRAIN;
      DRAIN:   if (send_fire)            state_d = FILL;
      default: state_d = FILL;
    endcase
  end

`ifdef DESER_SCHED_PARTIAL_FLUSH_EN
  always_comb begin
    send_len_d = send_len_q;
    if (send_fire || idx_wrap) begin
      send_len_d = N_LEN;
    end else if (flush_go) begin
      send_len_d = xfer ? ({1'b0, idx} + (SEL_W + 1)'(1)) : {1'b0, idx};
    end
  end

  assign send_len = send_len_q;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= FILL;
`ifdef DESER_SCHED_PARTIAL_FLUSH_EN
      send_len_q <= N_LEN;
`endif
    end else begin
      state_q <= state_d;
`ifdef DESER_SCHED_PARTIAL_FLUSH_EN
      send_len_q <= send_len_d;
`endif
    end
  end

endmodule
